// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial register datapath
// (serializer and serial-in receiver).
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } ser_state_e;

  localparam int SER_MAX_WIDTH = 32;

  function automatic logic ser_parity(
    input logic [SER_MAX_WIDTH-1:0] d
  );
    return ^d;
  endfunction

endpackage

// File: rtl/bit_counter.sv
// Loadable down-counter with zero flag; holds at zero,
// never wraps.
module bit_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;
  assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/register_serializer.sv
// MSB-first parallel-in serial-out transmitter with handshake.
// Even parity bit appended when SERIALIZER_PARITY_EN is defined.
module register_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] din,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  ser_state_e       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             first_q;
  logic             accept;
  logic             last;
  logic             cnt_zero;
  logic [CW-1:0]    cnt;

`ifdef SERIALIZER_PARITY_EN
  logic                     par_q, par_d;
  logic [SER_MAX_WIDTH-1:0] din_ext;
`endif

  bit_counter #(
    .W(CW)
  ) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (accept),
    .load_val_i(CW'(WIDTH - 1)),
    .dec_i     (state_q == SHIFT),
    .count_o   (cnt),
    .zero_o    (cnt_zero)
  );

  // Final bit of a frame: parity cycle if present, else last data bit.
`ifdef SERIALIZER_PARITY_EN
  assign last = (state_q == PAR);
`else
  assign last = (state_q == SHIFT) && cnt_zero;
`endif

  assign accept      = load_valid && load_ready;
  assign load_ready  = (state_q == IDLE) || last;
  assign done        = last;
  assign busy        = (state_q != IDLE);
  assign sout_valid  = busy;
  assign frame_start = first_q;

  always_comb begin
    sout = 1'b0;
    if (state_q == SHIFT) begin
      sout = shift_q[WIDTH-1];
    end
`ifdef SERIALIZER_PARITY_EN
    else if (state_q == PAR) begin
      sout = par_q;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
`ifdef SERIALIZER_PARITY_EN
    par_d   = par_q;
    din_ext = '0;
    din_ext[WIDTH-1:0] = din;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = SHIFT;
      end
      SHIFT: begin
        shift_d = shift_q << 1;
        if (cnt_zero) begin
`ifdef SERIALIZER_PARITY_EN
          state_d = PAR;
`else
          state_d = accept ? SHIFT : IDLE;
`endif
        end
      end
      PAR: begin
        state_d = accept ? SHIFT : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      shift_d = din;
`ifdef SERIALIZER_PARITY_EN
      par_d   = ser_parity(din_ext);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      first_q <= accept;
    end
  end

`ifdef SERIALIZER_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

endmodule

// File: tb/tb_register_serializer.sv
// Randomized and directed bench for register_serializer against
// a frame-queue reference model.
module tb_register_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load_valid;
  logic         load_ready;
  logic [W-1:0] din;
  logic         sout, sout_valid, frame_start, busy, done;

  logic         lv1;
  logic         lr1;
  logic [0:0]   din1;
  logic         so1, sv1, fs1, bz1, dn1;

  int errors = 0;
  int checks = 0;

  logic exp_q[$];
  bit   exp_first;

  always #5 clk = ~clk;

  register_serializer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .din        (din),
    .sout       (sout),
    .sout_valid (sout_valid),
    .frame_start(frame_start),
    .busy       (busy),
    .done       (done)
  );

  register_serializer #(.WIDTH(1)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (lv1),
    .load_ready (lr1),
    .din        (din1),
    .sout       (so1),
    .sout_valid (sv1),
    .frame_start(fs1),
    .busy       (bz1),
    .done       (dn1)
  );

  // Called at a negedge: compare, drive, clock, advance model.
  task automatic cycle(input logic v, input logic [W-1:0] d,
                       input string tag);
    logic e_sout, e_val, e_rdy, e_done;
    bit acc;
    int ones;
    e_val  = (exp_q.size() > 0);
    e_sout = e_val ? exp_q[0] : 1'b0;
    e_rdy  = (exp_q.size() <= 1);
    e_done = (exp_q.size() == 1);
    checks++;
    if ({sout, sout_valid, busy} !== {e_sout, e_val, e_val}) begin
      errors++;
      $display("FAIL %s sout/valid/busy got %b%b%b want %b%b%b",
               tag, sout, sout_valid, busy, e_sout, e_val, e_val);
    end
    checks++;
    if ({load_ready, done, frame_start} !==
        {e_rdy, e_done, exp_first}) begin
      errors++;
      $display("FAIL %s ready/done/start got %b%b%b want %b%b%b",
               tag, load_ready, done, frame_start,
               e_rdy, e_done, exp_first);
    end
    load_valid = v;
    din = d;
    @(posedge clk);
    acc = v && e_rdy;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    exp_first = 0;
    if (acc) begin
      exp_first = 1;
      for (int i = W - 1; i >= 0; i--) exp_q.push_back(d[i]);
`ifdef SERIALIZER_PARITY_EN
      ones = $countones(d);
      exp_q.push_back(logic'(ones % 2));
`endif
    end
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && exp_q.size() > 0; i++)
      cycle(1'b0, '0, tag);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s drain timeout got %0d want 0",
               tag, exp_q.size());
    end
    cycle(1'b0, '0, tag);
  endtask

  task automatic test_reset();
    checks++;
    if ({sout, sout_valid, frame_start, busy, done, load_ready}
        !== 6'b000001) begin
      errors++;
      $display("FAIL reset outs got %b want 000001",
               {sout, sout_valid, frame_start, busy, done,
                load_ready});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    cycle(1'b1, 8'hA5, "a5");
    drain("a5");
  endtask

  task automatic test_back_to_back();
    cycle(1'b1, 8'hA5, "b2b");
    for (int i = 0; i < 30; i++) begin
      if (exp_q.size() <= 1)
        cycle(1'b1, 8'h3C, "b2b");
      else
        cycle(1'b1, 8'h3C, "b2b");
      if (i == 8) break;
    end
    drain("b2b");
  endtask

  task automatic test_ignore();
    cycle(1'b1, 8'h00, "ign");
    cycle(1'b0, 8'h00, "ign");
    cycle(1'b0, 8'h00, "ign");
    cycle(1'b1, 8'hFF, "ign");
    drain("ign");
  endtask

  task automatic test_parity();
`ifdef SERIALIZER_PARITY_EN
    cycle(1'b1, 8'h07, "par07");
    drain("par07");
    cycle(1'b1, 8'h03, "par03");
    drain("par03");
`endif
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 8'hF0, "rstmid");
    repeat (3) cycle(1'b0, '0, "rstmid");
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({sout, sout_valid, busy, done, frame_start, load_ready}
        !== 6'b000001) begin
      errors++;
      $display("FAIL rstmid async got %b want 000001",
               {sout, sout_valid, busy, done, frame_start,
                load_ready});
    end
    exp_q.delete();
    exp_first = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 8'h81, "post81");
    drain("post81");
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++)
      cycle(($urandom % 3) != 0, W'($urandom), "rand");
    drain("rand");
  endtask

  task automatic test_width1();
    logic e_so, e_fs, e_dn, e_rd;
    lv1 = 1'b1;
    din1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
`ifdef SERIALIZER_PARITY_EN
      e_so = 1'b1;
      e_fs = (i % 2 == 0);
      e_dn = (i % 2 == 1);
      e_rd = (i % 2 == 1);
`else
      e_so = 1'b1;
      e_fs = 1'b1;
      e_dn = 1'b1;
      e_rd = 1'b1;
`endif
      checks++;
      if ({so1, sv1, fs1, dn1, lr1} !==
          {e_so, 1'b1, e_fs, e_dn, e_rd}) begin
        errors++;
        $display("FAIL w1 cyc%0d got %b want %b", i,
                 {so1, sv1, fs1, dn1, lr1},
                 {e_so, 1'b1, e_fs, e_dn, e_rd});
      end
      @(negedge clk);
    end
    lv1 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    load_valid = 1'b0;
    din = '0;
    lv1 = 1'b0;
    din1 = '0;
    exp_first = 0;
    repeat (2) @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_ignore();
    test_parity();
    test_reset_mid();
    test_random();
    test_width1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/register_serializer.md
# register_serializer

Parallel-in, serial-out transmitter for the 8-bit register datapath. It accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clock, MSB first. The optional even parity bit follows the data. Its serial stream feeds the downstream serial-in register, which reassembles the word.

## Interface
Parameters:
- WIDTH, 8, data word width in bits (legal range 1..32).

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- load_valid  input  1  din is valid this cycle.
- load_ready  output  1  block will accept a word at this posedge.
- din  input  WIDTH  parallel word to transmit; bit WIDTH-1 is sent first.
- sout  output  1  serial data bit.
- sout_valid  output  1  sout carries a frame bit this cycle.
- frame_start  output  1  one-cycle pulse on the first bit of a frame.
- busy  output  1  a frame is in progress (state != IDLE).
- done  output  1  one-cycle pulse on the last bit of a frame (parity bit when enabled).

## Operation
- States: IDLE, SHIFT, PAR (PAR exists only when parity is compiled in).
- Reset (rst_n low, asynchronous):
  - state=IDLE; shift register=0; bit counter=0.
  - Outputs: sout=0, sout_valid=0, frame_start=0, busy=0, done=0, load_ready=1.
- Accept: a word is accepted when load_valid && load_ready at a posedge.
  - On accept: shift_reg<=din; count<=WIDTH-1; state<=SHIFT.
  - In the same edge, parity accumulator <= XOR reduction of din.
- SHIFT:
  - sout=shift_reg[WIDTH-1]; sout_valid=1.
  - Each posedge: shift left by one (zero fill) and decrement count.
  - At count==0: go to PAR if parity is enabled, else end the frame.
- PAR: sout=parity (even parity; the total count of 1s including the parity bit is even); sout_valid=1; lasts one cycle.
- Ending a frame: go to IDLE, or straight to SHIFT if a new word is accepted at the same edge (back-to-back).
- load_ready=1 in IDLE and in the final bit cycle of a frame, and 0 otherwise.
- load_valid while load_ready=0 is ignored; din is not sampled.
- frame_start=1 during the first SHIFT cycle of each frame, including back-to-back frames.
- done=1 during the final bit cycle; it coincides with load_ready=1 in that cycle.
- Counter width is clog2(WIDTH) with a minimum of 1 bit.
- Arithmetic: the counter never wraps; it is reloaded on accept. Parity is the XOR of WIDTH bits.
- WIDTH=1: SHIFT lasts one cycle, so frame_start and done are both high in that cycle.

## Timing
- Latency: word accepted at edge N; first bit on sout during cycle N+1.
- Data bits occupy cycles N+1..N+WIDTH; the parity bit, when enabled, occupies cycle N+WIDTH+1.
- Throughput: one bit per cycle with no idle gap between back-to-back frames.
- All outputs are registered or decoded from registered state only; there is no combinational path from din or load_valid to any output.
- Reset mid-frame: outputs reach their reset values immediately (asynchronously). The partial frame is discarded and is not resumed after rst_n rises.
- First accept after rst_n rises: possible at the first posedge.

## Configuration
- SERIALIZER_PARITY_EN:
  - Defined: PAR state is present; frame length is WIDTH+1 cycles; done and load_ready move to the parity cycle.
  - Undefined: PAR state and the parity accumulator are absent; frame length is WIDTH cycles.

## Structure
- Shared package (serial_pkg):
  - State enum: IDLE, SHIFT, PAR.
  - Constant SER_MAX_WIDTH=32.
  - Parity function (XOR reduction), shared with the serial-in receiver.
- Sub-module: bit_counter (loadable down-counter with a zero flag). It is natural and reusable by the receiver.
- Remaining logic is a single FSM plus the shift register in register_serializer.

## Test plan
- Reset then load 8'hA5 (no parity) -> sout 1,0,1,0,0,1,0,1 in cycles 1..8; frame_start in cycle 1; done in cycle 8; busy back to 0 in cycle 9.
- Back-to-back: 8'hA5 then 8'h3C, with load_valid held -> 16 contiguous valid bits 10100101 00111100; frame_start in cycles 1 and 9; no gap.
- SERIALIZER_PARITY_EN defined, load 8'h07 -> data bits 00000111, parity bit 1 in cycle 9, done in cycle 9; load 8'h03 -> parity bit 0.
- load_valid asserted with din=8'hFF during cycle 3 of an 8'h00 frame -> ignored; sout stays 0 through cycle 8; load_ready=0 in cycles 1..7.
- rst_n pulled low after 3 bits of 8'hF0 -> sout, sout_valid, busy and done go to 0 immediately; after release, a new 8'h81 transmits cleanly as 1,0,0,0,0,0,0,1.
- WIDTH=1, load 1'b1 -> sout=1 for one cycle with frame_start=done=1; load_ready=1 throughout.
